sp_ram_banked: RTL and testbench

- Parametrised successor of the single-port data/instruction RAM wrapper.
- Builds a DATA_WIDTH x (RAM_SIZE bytes) RAM from byte-wide single-port macros, arranged as NUM_GROUPS word-interleaved groups of LANES byte lanes.
- Adds a registered read-select pipeline with a read-valid flag, a request grant, and a hardware initialisation sequencer that fills the whole array with INIT_VALUE after reset or on request.
- Sits between the core/AXI memory muxes and the SRAM macros.

---
 rtl/sp_ram_pkg.sv | 25 ++
 rtl/sp_ram_banked_if.sv | 25 ++
 rtl/sp_ram_banked_macro.sv | 46 ++++
 rtl/sp_ram_init_fsm.sv | 72 +++++++
 rtl/sp_ram_banked.sv | 148 ++++++++++++++
 tb/tb_sp_ram_banked.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and width helpers for the banked single-port RAM.
// Imported by the init sequencer and the top level.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_DONE = 2'd2
    } init_state_e;

    localparam logic [7:0] INIT_VALUE_DEF = 8'h00;

    function automatic int lanes_f(input int dw);
        return dw / 8;
    endfunction

    // A single group needs no group-select bits at all.
    function automatic int grp_bits_f(input int ram, input int dw,
                                      input int depth);
        int ng;
        ng = ram / ((dw / 8) * depth);
        return (ng <= 1) ? 0 : $clog2(ng);
    endfunction

endpackage

// File: rtl/sp_ram_banked_if.sv
// Request/response bus between the memory muxes and the banked RAM.
// The master issues requests; the RAM answers with grant and read data.
interface sp_ram_banked_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) ();
    logic                    en_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic                    gnt_o;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;

    modport master (
        output en_i, addr_i, wdata_i, we_i, be_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  en_i, addr_i, wdata_i, we_i, be_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sp_ram_banked_macro.sv
// Byte-wide single-port RAM model and the 2048x8 macro shell.
// Reads return data one clock after CSN low with WEN high.
module sp_ram_byte #(
    parameter int DEPTH = 2048
) (
    output logic [7:0]               Q,
    input  logic                     CK,
    input  logic                     CSN,
    input  logic                     TBYPASS,
    input  logic                     WEN,
    input  logic [$clog2(DEPTH)-1:0] A,
    input  logic [7:0]               D
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Writes leave Q alone so an in-flight read result survives.
    always_ff @(posedge CK) begin
        if (!CSN) begin
            if (!WEN) r_mem[A] <= D;
            else      r_q      <= r_mem[A];
        end
    end

    assign Q = TBYPASS ? D : r_q;
endmodule

module ST_SPHDL_2048x8m8_L (
    output logic [7:0]  Q,
    input  logic        CK,
    input  logic        CSN,
    input  logic        TBYPASS,
    input  logic        WEN,
    input  logic [10:0] A,
    input  logic [7:0]  D
);
    sp_ram_byte #(.DEPTH(2048)) u_core (
        .Q       (Q),
        .CK      (CK),
        .CSN     (CSN),
        .TBYPASS (TBYPASS),
        .WEN     (WEN),
        .A       (A),
        .D       (D)
    );
endmodule

// File: rtl/sp_ram_init_fsm.sv
// Fill sequencer: walks every macro address once, writing INIT_VALUE.
// Drives the macro-mux override and the busy/done status flags.
module sp_ram_init_fsm
    import sp_ram_pkg::*;
#(
    parameter int MACRO_DEPTH   = 2048,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic                           init_req_i,
    input  logic                           bypass_en_i,
    output logic                           init_busy,
    output logic                           init_we,
    output logic [$clog2(MACRO_DEPTH)-1:0] init_addr,
    output logic                           init_done_o
);
    localparam int AW = $clog2(MACRO_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(MACRO_DEPTH - 1);
    localparam init_state_e RST_ST = INIT_ON_RESET ? ST_INIT : ST_IDLE;

    init_state_e   r_state, w_next;
    logic [AW-1:0] r_cnt, w_cnt;
    logic          r_done, w_done;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= RST_ST;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_done = r_done;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (init_req_i) begin
                    w_next = ST_INIT;
                    w_cnt  = '0;
                    w_done = 1'b0;
                end
            end
            ST_INIT: begin
                // Bypass freezes the walk so no location is skipped.
                if (!bypass_en_i) begin
                    if (r_cnt == LAST) begin
                        w_next = ST_DONE;
                        w_cnt  = '0;
                        w_done = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        init_busy   = (r_state == ST_INIT);
        init_we     = init_busy & ~bypass_en_i;
        init_addr   = r_cnt;
        init_done_o = r_done;
    end
endmodule

// File: rtl/sp_ram_banked.sv
// Banked single-port RAM built from byte macros in interleaved groups,
// with a one-cycle registered read path and a hardware fill sequencer.
module sp_ram_banked
    import sp_ram_pkg::*;
#(
    parameter int         RAM_SIZE      = 32768,
    parameter int         DATA_WIDTH    = 32,
    parameter int         MACRO_DEPTH   = 2048,
    parameter bit         INIT_ON_RESET = 1'b1,
    parameter logic [7:0] INIT_VALUE    = INIT_VALUE_DEF
) (
    input  logic          clk,
    input  logic          rstn_i,
    input  logic          bypass_en_i,
    input  logic          init_req_i,
    output logic          init_busy_o,
    output logic          init_done_o,
    sp_ram_banked_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE);
    localparam int LANES      = lanes_f(DATA_WIDTH);
    localparam int OFS_BITS   = $clog2(LANES);
    localparam int NUM_GROUPS = RAM_SIZE / (LANES * MACRO_DEPTH);
    localparam int GRP_BITS   = grp_bits_f(RAM_SIZE, DATA_WIDTH, MACRO_DEPTH);
    localparam int GW         = (GRP_BITS == 0) ? 1 : GRP_BITS;
    localparam int MA_BITS    = $clog2(MACRO_DEPTH);
    localparam int NM         = NUM_GROUPS * LANES;

    if (DATA_WIDTH % 8 != 0) begin : g_err_dw
        $error("sp_ram_banked: DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_GROUPS < 1) begin : g_err_ng
        $error("sp_ram_banked: NUM_GROUPS must be at least 1");
    end
    if ((NUM_GROUPS & (NUM_GROUPS - 1)) != 0) begin : g_err_pow
        $error("sp_ram_banked: NUM_GROUPS must be a power of two");
    end

    logic               w_init_busy;
    logic               w_init_we;
    logic [MA_BITS-1:0] w_init_addr;
    logic               w_gnt, w_rd, w_wr;
    logic [GW-1:0]      w_grp;
    logic [MA_BITS-1:0] w_ma;
    logic               w_unused;

    logic               w_csn [NM];
    logic               w_wen [NM];
    logic [MA_BITS-1:0] w_a   [NM];
    logic [7:0]         w_d   [NM];
    logic [7:0]         w_q   [NM];

    logic               r_rvalid;
    logic [GW-1:0]      r_grp;

    sp_ram_init_fsm #(
        .MACRO_DEPTH   (MACRO_DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .init_req_i  (init_req_i),
        .bypass_en_i (bypass_en_i),
        .init_busy   (w_init_busy),
        .init_we     (w_init_we),
        .init_addr   (w_init_addr),
        .init_done_o (init_done_o)
    );

    if (GRP_BITS == 0) begin : g_grp0
        assign w_grp = '0;
    end else begin : g_grpn
        assign w_grp = bus.addr_i[OFS_BITS +: GRP_BITS];
    end

    assign w_ma        = bus.addr_i[ADDR_WIDTH-1 -: MA_BITS];
    assign w_unused    = ^bus.addr_i;
    assign init_busy_o = w_init_busy;
    assign w_gnt       = bus.en_i & ~w_init_busy;
    assign w_rd        = w_gnt & ~bus.we_i;
    assign w_wr        = w_gnt & bus.we_i;
    assign bus.gnt_o   = w_gnt;

    // Macro i holds lane (i % LANES) of group (i / LANES).
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            w_csn[i] = 1'b1;
            w_wen[i] = 1'b1;
            w_a[i]   = w_ma;
            w_d[i]   = bus.wdata_i[(i % LANES)*8 +: 8];
            if (w_init_busy) begin
                w_csn[i] = ~w_init_we;
                w_wen[i] = ~w_init_we;
                w_a[i]   = w_init_addr;
                w_d[i]   = INIT_VALUE;
            end else if (w_grp == GW'(i / LANES)) begin
                w_csn[i] = ~(w_rd | (w_wr & bus.be_i[i % LANES]));
                w_wen[i] = ~(w_wr & ~bypass_en_i);
            end
        end
    end

    for (genvar i = 0; i < NM; i++) begin : g_mac
        if (MACRO_DEPTH == 2048) begin : g_st
            ST_SPHDL_2048x8m8_L u_mac (
                .Q       (w_q[i]),
                .CK      (clk),
                .CSN     (w_csn[i]),
                .TBYPASS (bypass_en_i),
                .WEN     (w_wen[i]),
                .A       (w_a[i]),
                .D       (w_d[i])
            );
        end else begin : g_beh
            sp_ram_byte #(.DEPTH(MACRO_DEPTH)) u_mac (
                .Q       (w_q[i]),
                .CK      (clk),
                .CSN     (w_csn[i]),
                .TBYPASS (bypass_en_i),
                .WEN     (w_wen[i]),
                .A       (w_a[i]),
                .D       (w_d[i])
            );
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rvalid <= 1'b0;
            r_grp    <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_grp <= w_grp;
        end
    end

    // Zero when idle keeps rdata_o free of uninitialised macro output.
    always_comb begin
        bus.rdata_o = '0;
        if (r_rvalid) begin
            for (int l = 0; l < LANES; l++) begin
                bus.rdata_o[l*8 +: 8] = w_q[int'(r_grp)*LANES + l];
            end
        end
    end

    assign bus.rvalid_o = r_rvalid;
endmodule

// File: tb/tb_sp_ram_banked.sv
// Directed plus random bench for sp_ram_banked against a flat byte-array
// model of the whole address space.
module tb_sp_ram_banked;
    logic clk = 1'b0;
    logic rstn, bypass, init_req, busy, done;
    logic [7:0] mem [32768];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [31:0] got, ex;
    logic [31:0] exq [5];

    always #5 clk = ~clk;

    sp_ram_banked_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

    sp_ram_banked u_dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .bypass_en_i (bypass),
        .init_req_i  (init_req),
        .init_busy_o (busy),
        .init_done_o (done),
        .bus         (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [14:0] a);
        logic [14:0] b;
        b = {a[14:2], 2'b00};
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    task automatic mwr(input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        logic [14:0] b;
        b = {a[14:2], 2'b00};
        for (int l = 0; l < 4; l++)
            if (be[l]) mem[b + 15'(l)] = d[l*8 +: 8];
    endtask

    task automatic mfill();
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        bus.en_i = 1'b1; bus.we_i = 1'b1;
        bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
        #1 chk("wr_gnt", 32'(bus.gnt_o), 32'd1);
        @(negedge clk);
        bus.en_i = 1'b0; bus.we_i = 1'b0;
        if (!bypass) mwr(a, d, be);
        chk("wr_rvalid", 32'(bus.rvalid_o), 32'd0);
    endtask

    task automatic rd(input logic [14:0] a, output logic [31:0] q);
        logic [31:0] e;
        bus.en_i = 1'b1; bus.we_i = 1'b0;
        bus.addr_i = a; bus.be_i = 4'h0;
        #1 chk("rd_gnt", 32'(bus.gnt_o), 32'd1);
        e = mrd(a);
        @(negedge clk);
        bus.en_i = 1'b0;
        chk("rd_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("rd_data", bus.rdata_o, e);
        q = bus.rdata_o;
    endtask

    // en_i is held high by the caller so grant suppression is observed.
    task automatic wait_init(input string tag);
        int n;
        logic bad;
        n = 0;
        bad = 1'b0;
        while (busy === 1'b1 && n < 3000) begin
            if (done !== 1'b0 || bus.gnt_o !== 1'b0) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        bus.en_i = 1'b0;
        chk({tag, "_len"}, 32'(n), 32'd2048);
        chk({tag, "_flags"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [14:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  be;

        rstn = 1'b0; bypass = 1'b0; init_req = 1'b0;
        bus.en_i = 1'b1; bus.we_i = 1'b0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        rstn = 1'b1;
        wait_init("por");
        mfill();

        rd(15'h7FFC, got);
        chk("top_word", got, 32'h0000_0000);

        wr(15'h0004, 32'hDEADBEEF, 4'b1111);
        wr(15'h0004, 32'h0000_5500, 4'b0010);
        rd(15'h0004, got);
        chk("be_merge", got, 32'hDEAD55EF);

        for (int k = 0; k < 5; k++)
            wr(15'(k * 4), 32'h1111_1111 * (k + 1), 4'hF);
        bus.en_i = 1'b1; bus.we_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.addr_i = 15'(k * 4);
            exq[k] = 32'h1111_1111 * (k + 1);
            @(negedge clk);
            chk("b2b_rvalid", 32'(bus.rvalid_o), 32'd1);
            chk("b2b_data", bus.rdata_o, exq[k]);
        end
        bus.en_i = 1'b0;

        bypass = 1'b1;
        wr(15'h0000, 32'hFFFF_FFFF, 4'hF);
        bypass = 1'b0;
        rd(15'h0000, got);
        chk("bypass_keep", got, 32'h1111_1111);

        init_req = 1'b1;
        bus.en_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 15'h0004;
        #1 chk("req_gnt", 32'(bus.gnt_o), 32'd1);
        @(negedge clk);
        init_req = 1'b0;
        chk("req_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("req_data", bus.rdata_o, 32'h2222_2222);
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_done", 32'(done), 32'd0);
        mfill();
        wait_init("req");
        for (int k = 0; k < 5; k++) begin
            rd(15'(k * 4), got);
            chk("post_init", got, 32'h0);
        end

        for (int i = 0; i < 80; i++) begin
            a  = 15'({$urandom_range(0, 31), 2'b00});
            if (i % 8 == 0) a = 15'h7F00 | a;
            w  = 1'($urandom);
            d  = $urandom;
            be = 4'($urandom);
            bus.en_i = 1'b1; bus.we_i = w;
            bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
            ex = mrd(a);
            if (w) mwr(a, d, be);
            @(negedge clk);
            chk("rnd_rvalid", 32'(bus.rvalid_o), 32'(!w));
            if (!w) chk("rnd_data", bus.rdata_o, ex);
        end
        bus.en_i = 1'b0;

        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (1000) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_rvalid", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        mfill();
        bus.en_i = 1'b1; bus.we_i = 1'b0;
        wait_init("mid");
        rd(15'h0040, got);
        rd(15'h7F04, got);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
